// File: rtl/keypad_scan.sv
// ============================================================================
//  Module      : keypad_scan
//  Description : 4x3 keypad column scanner with row synchronizer, lowest-code
//                priority across a full scan, and a scan-rate debounce FSM.
//                Emits key codes 1..12 (0 = no key), with a one-clk strobe
//                on each newly accepted nonzero code.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module keypad_scan #(
    parameter int SCAN_DIV  = 25000,
    parameter int DEB_SCANS = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] key_row,
    output logic [2:0] key_col,
    output logic [3:0] key_data,
    output logic       key_valid,
    output logic       key_held
);

    localparam int c_DIV_W = $clog2(SCAN_DIV);
    localparam int c_CNT_W = $clog2(DEB_SCANS + 1);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        PRESS_DB   = 2'd1,
        HELD       = 2'd2,
        RELEASE_DB = 2'd3
    } state_t;

    logic [3:0]         r_row_s1, r_row_s2;
    logic [c_DIV_W-1:0] r_div;
    logic [1:0]         r_col_idx;
    logic [3:0]         r_acc;
    state_t             r_state, w_state_n;
    logic [3:0]         r_cand, w_cand_n;
    logic [c_CNT_W-1:0] r_cnt, w_cnt_n, w_cnt_inc;
    logic [3:0]         w_data_n;
    logic               w_valid_n;
    logic               w_tick, w_scan_end;
    logic [3:0]         w_col_code, w_merged;

    // Combine two codes where 0 means "nothing pressed"; the smaller code wins.
    function automatic logic [3:0] lowest(input logic [3:0] a, input logic [3:0] b);
        if (a == 4'd0)      return b;
        else if (b == 4'd0) return a;
        else if (a < b)     return a;
        else                return b;
    endfunction

    assign w_tick     = (r_div == c_DIV_W'(SCAN_DIV - 1));
    assign w_scan_end = w_tick && (r_col_idx == 2'd2);
    assign w_merged   = lowest(r_acc, w_col_code);
    assign w_cnt_inc  = (r_cnt >= c_CNT_W'(DEB_SCANS)) ? r_cnt : r_cnt + 1'b1;
    assign key_held   = (r_state == HELD) || (r_state == RELEASE_DB);

    // Two-flop synchronizer on the raw row lines.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_row_s1 <= '0;
            r_row_s2 <= '0;
        end else begin
            r_row_s1 <= key_row;
            r_row_s2 <= r_row_s1;
        end
    end

    // Scan-rate divider and column rotation; the column advances on each tick.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_div     <= '0;
            r_col_idx <= 2'd0;
            key_col   <= 3'b001;
        end else begin
            r_div <= w_tick ? '0 : r_div + 1'b1;
            if (w_tick) begin
                r_col_idx <= (r_col_idx == 2'd2) ? 2'd0 : r_col_idx + 2'd1;
                key_col   <= {key_col[1:0], key_col[2]};
            end
        end
    end

    // Code of the lowest pressed row on the current column (row 3 maps to 10..12).
    always_comb begin
        w_col_code = 4'd0;
        for (int r = 3; r >= 0; r--) begin
            if (r_row_s2[r]) w_col_code = 4'(3 * r + int'(r_col_idx) + 1);
        end
    end

    // Accumulate the lowest code over one full scan; cleared after column 2.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)             r_acc <= '0;
        else if (w_scan_end) r_acc <= '0;
        else if (w_tick)     r_acc <= w_merged;
    end

    // Debounce FSM state register and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_cand    <= '0;
            r_cnt     <= '0;
            key_data  <= '0;
            key_valid <= 1'b0;
        end else begin
            r_state   <= w_state_n;
            r_cand    <= w_cand_n;
            r_cnt     <= w_cnt_n;
            key_data  <= w_data_n;
            key_valid <= w_valid_n;
        end
    end

    // Debounce next-state logic; advances only at the end of each full scan.
    always_comb begin
        w_state_n = r_state;
        w_cand_n  = r_cand;
        w_cnt_n   = r_cnt;
        w_data_n  = key_data;
        w_valid_n = 1'b0;
        if (w_scan_end) begin
            case (r_state)
                IDLE: begin
                    if (w_merged != 4'd0) begin
                        w_state_n = PRESS_DB;
                        w_cand_n  = w_merged;
                        w_cnt_n   = c_CNT_W'(1);
                    end
                end
                PRESS_DB: begin
                    if (w_merged == 4'd0) begin
                        w_state_n = IDLE;
                    end else if (w_merged == r_cand) begin
                        w_cnt_n = w_cnt_inc;
                        if (w_cnt_inc == c_CNT_W'(DEB_SCANS)) begin
                            w_state_n = HELD;
                            w_data_n  = r_cand;
                            w_valid_n = 1'b1;
                        end
                    end else begin
                        w_cand_n = w_merged;
                        w_cnt_n  = c_CNT_W'(1);
                    end
                end
                HELD: begin
                    if (w_merged != key_data) begin
                        w_state_n = RELEASE_DB;
                        w_cand_n  = w_merged;
                        w_cnt_n   = c_CNT_W'(1);
                    end
                end
                RELEASE_DB: begin
                    if (w_merged == key_data) begin
                        // Momentary disturbance: fall back without re-strobing.
                        w_state_n = HELD;
                    end else if (w_merged == r_cand) begin
                        w_cnt_n = w_cnt_inc;
                        if (w_cnt_inc == c_CNT_W'(DEB_SCANS)) begin
                            w_data_n = r_cand;
                            if (r_cand == 4'd0) begin
                                w_state_n = IDLE;
                            end else begin
                                w_state_n = HELD;
                                w_valid_n = 1'b1;
                            end
                        end
                    end else begin
                        w_cand_n = w_merged;
                        w_cnt_n  = c_CNT_W'(1);
                    end
                end
                default: w_state_n = IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_keypad_scan.sv
// ============================================================================
//  Module      : tb_keypad_scan
//  Description : Directed, table-driven bench for keypad_scan with a
//                behavioural keypad that answers the driven column.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_keypad_scan;

    localparam int SCAN_DIV  = 4;
    localparam int DEB_SCANS = 3;

    typedef struct {
        logic [12:0] mask;
        int          scans;
        int          exp_data;
        int          exp_pulses;
        int          exp_held;
    } step_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  key_row;
    logic [2:0]  key_col;
    logic [3:0]  key_data;
    logic        key_valid;
    logic        key_held;
    logic [12:0] pressed;

    int    total = 0;
    int    bad   = 0;
    step_t steps[$];

    always #5 clk = ~clk;

    keypad_scan #(
        .SCAN_DIV  (SCAN_DIV),
        .DEB_SCANS (DEB_SCANS)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .key_row   (key_row),
        .key_col   (key_col),
        .key_data  (key_data),
        .key_valid (key_valid),
        .key_held  (key_held)
    );

    // Keypad model: a pressed key (bit = its code) shorts its row to its column.
    always_comb begin
        key_row = '0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 3; c++)
                if (pressed[3 * r + c + 1] && key_col[c]) key_row[r] = 1'b1;
    end

    function automatic logic [12:0] keys(input int a, input int b = 0);
        logic [12:0] v;
        v = '0;
        if (a != 0) v[a] = 1'b1;
        if (b != 0) v[b] = 1'b1;
        return v;
    endfunction

    function automatic void add(input logic [12:0] m, input int n, input int d,
                                input int p, input int h);
        step_t s;
        s.mask = m; s.scans = n; s.exp_data = d; s.exp_pulses = p; s.exp_held = h;
        steps.push_back(s);
    endfunction

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Run until the next end-of-scan edge (column 2 -> column 0), counting strobe cycles.
    task automatic run_scan(output int pulses);
        logic [2:0] prev;
        bit         done;
        pulses = 0;
        done   = 1'b0;
        prev   = key_col;
        for (int n = 0; n < 40 && !done; n++) begin
            @(posedge clk);
            #1;
            if (key_valid) pulses++;
            if (prev == 3'b100 && key_col == 3'b001) done = 1'b1;
            prev = key_col;
        end
        if (!done) check("scan_timeout", 0, 1);
    endtask

    task automatic run_step(input step_t s, input string tag);
        int p;
        int sum;
        pressed = s.mask;
        sum = 0;
        for (int i = 0; i < s.scans; i++) begin
            run_scan(p);
            sum += p;
        end
        check({tag, "_data"},  int'(key_data), s.exp_data);
        check({tag, "_valid"}, sum,            s.exp_pulses);
        check({tag, "_held"},  int'(key_held), s.exp_held);
    endtask

    initial begin
        int    p;
        step_t s;

        // Clean press of 5 and release
        add(keys(5), 2, 0, 0, 0);
        add(keys(5), 1, 5, 1, 1);
        add(keys(5), 7, 5, 0, 1);
        add(keys(0), 2, 5, 0, 1);
        add(keys(0), 1, 0, 0, 0);
        // Bounce: 2 scans, gap, 3 scans
        add(keys(5), 2, 0, 0, 0);
        add(keys(0), 1, 0, 0, 0);
        add(keys(5), 2, 0, 0, 0);
        add(keys(5), 1, 5, 1, 1);
        add(keys(0), 3, 0, 0, 0);
        // Candidate change during press debounce
        add(keys(5), 2, 0, 0, 0);
        add(keys(8), 2, 0, 0, 0);
        add(keys(8), 1, 8, 1, 1);
        add(keys(0), 3, 0, 0, 0);
        // Simultaneous keys, and '#'
        add(keys(2, 9), 3, 2, 1, 1);
        add(keys(0), 3, 0, 0, 0);
        add(keys(4, 2), 3, 2, 1, 1);
        add(keys(0), 3, 0, 0, 0);
        add(keys(12), 3, 12, 1, 1);
        add(keys(0), 3, 0, 0, 0);
        add(keys(10, 11), 3, 10, 1, 1);
        add(keys(0), 3, 0, 0, 0);
        // Slide 4 -> 7 without release
        add(keys(4), 3, 4, 1, 1);
        add(keys(7), 2, 4, 0, 1);
        add(keys(7), 1, 7, 1, 1);
        add(keys(0), 3, 0, 0, 0);
        // Glitch while held
        add(keys(5), 3, 5, 1, 1);
        add(keys(0), 1, 5, 0, 1);
        add(keys(5), 1, 5, 0, 1);
        add(keys(5), 2, 5, 0, 1);

        pressed = '0;
        rst     = 1'b1;
        #2;
        check("rst_col",   int'(key_col),   1);
        check("rst_data",  int'(key_data),  0);
        check("rst_valid", int'(key_valid), 0);
        check("rst_held",  int'(key_held),  0);
        #20;
        @(negedge clk);
        rst = 1'b0;
        run_scan(p);

        foreach (steps[i]) run_step(steps[i], $sformatf("step%0d", i));

        // Asynchronous reset while HELD with key 5, between clock edges
        #3;
        rst = 1'b1;
        #1;
        check("arst_data",  int'(key_data),  0);
        check("arst_col",   int'(key_col),   1);
        check("arst_valid", int'(key_valid), 0);
        check("arst_held",  int'(key_held),  0);
        @(negedge clk);
        rst     = 1'b0;
        pressed = '0;
        run_scan(p);

        // Progress restarts cleanly after reset
        s.mask = keys(5); s.scans = 2; s.exp_data = 0; s.exp_pulses = 0; s.exp_held = 0;
        run_step(s, "post_rst_a");
        s.scans = 1; s.exp_data = 5; s.exp_pulses = 1; s.exp_held = 1;
        run_step(s, "post_rst_b");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
